multicycle_controller: RTL and testbench

- Control FSM that sequences a multicycle variant of the RV32I datapath: one shared memory port, a registered instruction (IR), and the ALU reused for PC+4, branch target and execute.
- Decodes op/funct3/funct7b5 from the instruction register and drives per-cycle datapath enables and mux selects.
- Replaces the combinational controller when the core is built in multicycle configuration.

---
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I datapath (master) and its controller (slave).
// The datapath drives the decoded IR fields and ALU flag; the controller returns enables and selects.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [3:0] ALUControl;
    logic [3:0] State;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
        input  RegWrite, ALUControl, State
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
        output RegWrite, ALUControl, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute over a shared
// memory port and reuses the ALU for PC+4, branch target and execute.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.slave bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSll  = 4'b0110;
    localparam logic [3:0] AluSrl  = 4'b0111;
    localparam logic [3:0] AluSra  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Only beq/bne are resolved here; the other branch funct3 codes never redirect the PC.
    assign branch_taken = (bus.funct3[2:1] == 2'b00) && (bus.Zero ^ bus.funct3[0]);

    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.RegWrite  = 1'b0;
        alu_op        = 2'b00;
        unique case (state_q)
            StFetch: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
            end
            StDecode: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            StMemAdr: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            StMemRead: bus.AdrSrc = 1'b1;
            StMemWb: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            StMemWrite: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            StExecuteR: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b10;
            end
            StExecuteI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = 2'b10;
            end
            StAluWb: bus.RegWrite = 1'b1;
            StBranch: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b01;
                bus.PCWrite = branch_taken;
            end
            StJal: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.op)
            OpStore:  bus.ImmSrc = 2'b01;
            OpBranch: bus.ImmSrc = 2'b10;
            OpJal:    bus.ImmSrc = 2'b11;
            default:  bus.ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        bus.ALUControl = AluAdd;
        case (alu_op)
            2'b01: bus.ALUControl = AluSub;
            2'b10: begin
                unique case (bus.funct3)
                    // op[5] separates R-type sub from addi, which has no subtract form.
                    3'b000: bus.ALUControl = (bus.funct7b5 & bus.op[5]) ? AluSub : AluAdd;
                    3'b001: bus.ALUControl = AluSll;
                    3'b010: bus.ALUControl = AluSlt;
                    3'b011: bus.ALUControl = AluSltu;
                    3'b100: bus.ALUControl = AluXor;
                    3'b101: bus.ALUControl = bus.funct7b5 ? AluSra : AluSrl;
                    3'b110: bus.ALUControl = AluOr;
                    3'b111: bus.ALUControl = AluAnd;
                    default: bus.ALUControl = AluAdd;
                endcase
            end
            default: bus.ALUControl = AluAdd;
        endcase
    end

    assign bus.State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes the expected per-cycle control
// vector, a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    //  RegWrite, ALUControl}
    typedef struct {
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Hand-written Moore table per state; the caller supplies ImmSrc, branch PCWrite and
    // the execute-stage ALUControl for the instruction under test.
    function automatic logic [20:0] expv(input logic [3:0] st, input logic [1:0] imm,
                                         input logic pcw_br, input logic [3:0] alu_x);
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, a, b;
        logic [3:0] alu;
        {pcw, adr, mw, irw, rw} = 5'b0;
        {rs, a, b} = 6'b0;
        alu = 4'b0000;
        case (st)
            4'd0: begin irw = 1; pcw = 1; b = 2'b10; rs = 2'b10; end
            4'd1: begin a = 2'b01; b = 2'b01; end
            4'd2: begin a = 2'b10; b = 2'b01; end
            4'd3: adr = 1;
            4'd4: begin rs = 2'b01; rw = 1; end
            4'd5: begin adr = 1; mw = 1; end
            4'd6: begin a = 2'b10; alu = alu_x; end
            4'd7: begin a = 2'b10; b = 2'b01; alu = alu_x; end
            4'd8: rw = 1;
            4'd9: begin a = 2'b10; alu = 4'b0001; pcw = pcw_br; end
            4'd10: begin a = 2'b01; b = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {st, pcw, adr, mw, irw, rs, a, b, imm, rw, alu};
    endfunction

    task automatic push(input logic [20:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // seq holds state numbers as nibbles, cycle 0 in the low nibble.
    task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [1:0] imm,
                       input logic pcw_br, input logic [3:0] alu_x, input logic [23:0] seq,
                       input int n);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
        for (int k = 0; k < n; k++) begin
            push(expv(seq[4*k +: 4], imm, pcw_br, alu_x), $sformatf("%s.c%0d", tag, k));
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [20:0] act;
            e   = exp_q.pop_front();
            act = {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUControl};
            n_vec++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.tag, act, e.v);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.op       = 7'b0000000;
        bus.funct3   = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.Zero     = 1'b0;
        @(posedge clk);
        #1;
        push(expv(4'd0, 2'b00, 1'b0, 4'd0), "reset");
        reset = 1'b0;

        run("lw",    7'b0000011, 3'b010, 0, 0, 2'b00, 0, 4'b0000, 24'h43210, 5);
        run("sw",    7'b0100011, 3'b010, 0, 0, 2'b01, 0, 4'b0000, 24'h5210, 4);
        run("sub",   7'b0110011, 3'b000, 1, 0, 2'b00, 0, 4'b0001, 24'h8610, 4);
        run("add",   7'b0110011, 3'b000, 0, 0, 2'b00, 0, 4'b0000, 24'h8610, 4);
        run("addi",  7'b0010011, 3'b000, 1, 0, 2'b00, 0, 4'b0000, 24'h8710, 4);
        run("sll",   7'b0110011, 3'b001, 0, 0, 2'b00, 0, 4'b0110, 24'h8610, 4);
        run("slti",  7'b0010011, 3'b010, 0, 0, 2'b00, 0, 4'b0101, 24'h8710, 4);
        run("sltu",  7'b0110011, 3'b011, 0, 0, 2'b00, 0, 4'b1001, 24'h8610, 4);
        run("xori",  7'b0010011, 3'b100, 0, 0, 2'b00, 0, 4'b0100, 24'h8710, 4);
        run("srl",   7'b0110011, 3'b101, 0, 0, 2'b00, 0, 4'b0111, 24'h8610, 4);
        run("srai",  7'b0010011, 3'b101, 1, 0, 2'b00, 0, 4'b1000, 24'h8710, 4);
        run("or",    7'b0110011, 3'b110, 0, 0, 2'b00, 0, 4'b0011, 24'h8610, 4);
        run("andi",  7'b0010011, 3'b111, 0, 0, 2'b00, 0, 4'b0010, 24'h8710, 4);
        run("beq_z1", 7'b1100011, 3'b000, 0, 1, 2'b10, 1, 4'b0000, 24'h910, 3);
        run("beq_z0", 7'b1100011, 3'b000, 0, 0, 2'b10, 0, 4'b0000, 24'h910, 3);
        run("bne_z1", 7'b1100011, 3'b001, 0, 1, 2'b10, 0, 4'b0000, 24'h910, 3);
        run("bne_z0", 7'b1100011, 3'b001, 0, 0, 2'b10, 1, 4'b0000, 24'h910, 3);
        run("blt_z1", 7'b1100011, 3'b100, 0, 1, 2'b10, 0, 4'b0000, 24'h910, 3);
        run("bge_z0", 7'b1100011, 3'b101, 0, 0, 2'b10, 0, 4'b0000, 24'h910, 3);
        run("jal",   7'b1101111, 3'b000, 0, 0, 2'b11, 0, 4'b0000, 24'h8A10, 4);
        run("ill",   7'b0000000, 3'b000, 0, 0, 2'b00, 0, 4'b0000, 24'h10, 2);

        // Reset arriving in MEMREAD must abandon the load without a register write.
        run("lw_rst", 7'b0000011, 3'b010, 0, 0, 2'b00, 0, 4'b0000, 24'h210, 3);
        reset = 1'b1;
        push(expv(4'd3, 2'b00, 1'b0, 4'd0), "lw_rst.memread");
        reset = 1'b0;
        run("after_rst", 7'b0000011, 3'b010, 0, 0, 2'b00, 0, 4'b0000, 24'h210, 3);

        @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
